// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants, index type and handshake state encoding
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_idx_t;

    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_ACK  = 1'b1
    } hs_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy-bit scoreboard with read-stall detection and write bypass exemption
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  NREGS = NREGS_DEF,
    parameter int  NRD   = NRD_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clr_i,
    input  logic [AW-1:0]     clr_idx_i,
    input  logic              set_i,
    input  logic [AW-1:0]     set_idx_i,
    input  logic              flush_i,
    input  logic [NRD*AW-1:0] rs_i,
    input  logic              byp_i,
    input  logic [AW-1:0]     byp_idx_i,
    output logic [NREGS-1:0]  busy_o,
    output logic              stall_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NRD-1:0]   port_stall;

    // Later updates override earlier ones: clear, then reserve, then flush.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) begin
            busy_d[clr_idx_i] = 1'b0;
        end
        if (set_i) begin
            busy_d[set_idx_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Stall uses the pre-update vector; a landing write to the same register lifts the stall.
    for (genvar k = 0; k < NRD; k++) begin : g_port
        logic [AW-1:0] rs;
        assign rs            = rs_i[k*AW +: AW];
        assign port_stall[k] = busy_q[rs] & ~(byp_i && (byp_idx_i == rs));
    end

    assign stall_o = |port_stall;
    assign busy_o  = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with stb/cyc/ack handshakes, write bypass and scoreboard
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int  XLEN  = XLEN_DEF,
    parameter int  NREGS = NREGS_DEF,
    parameter int  NRD   = NRD_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                stb_read_i,
    input  logic                cyc_read_i,
    input  logic [NRD*AW-1:0]   op_rs_i,
    output logic                ack_read_o,
    output logic [NRD*XLEN-1:0] reg_rs_o,
    input  logic                stb_write_i,
    input  logic                cyc_write_i,
    input  logic [AW-1:0]       op_rd_i,
    input  logic [XLEN-1:0]     reg_rd_i,
    output logic                ack_write_o,
    input  logic                rsv_i,
    input  logic [AW-1:0]       rsv_rd_i,
    input  logic                flush_i,
    output logic [NREGS-1:0]    busy_o
);

    hs_state_t rd_state_q;
    hs_state_t rd_state_d;
    hs_state_t wr_state_q;
    hs_state_t wr_state_d;

    logic                wr_accept;
    logic                wr_en;
    logic                rd_accept;
    logic                rd_stall;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD*XLEN-1:0] reg_rs_q;
    logic [NRD*XLEN-1:0] reg_rs_d;

    (* syn_ramstyle = "block_ram" *) logic [XLEN-1:0] regs_mem [NREGS];

    assign wr_accept = stb_write_i & cyc_write_i & (wr_state_q == HS_IDLE);
    assign wr_en     = wr_accept & (op_rd_i != '0);
    assign rd_accept = stb_read_i & cyc_read_i & (rd_state_q == HS_IDLE) & ~rd_stall;

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (wr_en),
        .clr_idx_i (op_rd_i),
        .set_i     (rsv_i),
        .set_idx_i (rsv_rd_i),
        .flush_i   (flush_i),
        .rs_i      (op_rs_i),
        .byp_i     (wr_en),
        .byp_idx_i (op_rd_i),
        .busy_o    (busy_o),
        .stall_o   (rd_stall)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_state_q <= HS_IDLE;
            wr_state_q <= HS_IDLE;
            reg_rs_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            reg_rs_q   <= reg_rs_d;
        end
    end

    // Once acked, the channel stays in HS_ACK until the requester drops stb.
    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            HS_IDLE: if (rd_accept)   rd_state_d = HS_ACK;
            HS_ACK:  if (!stb_read_i) rd_state_d = HS_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            HS_IDLE: if (wr_accept)    wr_state_d = HS_ACK;
            HS_ACK:  if (!stb_write_i) wr_state_d = HS_IDLE;
        endcase
    end

    always_comb begin
        ack_read_o  = (rd_state_q == HS_ACK) & stb_read_i;
        ack_write_o = (wr_state_q == HS_ACK) & stb_write_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i && wr_en) begin
            regs_mem[op_rd_i] <= reg_rd_i;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] rs;
        assign rs = op_rs_i[k*AW +: AW];
        assign rd_data[k*XLEN +: XLEN] = (rs == '0)                  ? '0 :
                                         (wr_en && (op_rd_i == rs)) ? reg_rd_i :
                                                                      regs_mem[rs];
    end

    assign reg_rs_d = rd_accept ? rd_data : reg_rs_q;
    assign reg_rs_o = reg_rs_q;

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the CPU register file: `NREGS` x `XLEN` registers with `NRD` read ports and one write port, all behind the stb/cyc/ack handshake. Same-cycle reads and writes are both served, with write-to-read bypass in place of write-priority stalling. An integrated scoreboard marks destination registers reserved by in-flight instructions and stalls reads of those registers until the write lands. Sits between the decode stage (read, reserve) and the writeback stage (write).

## Interface
- `XLEN`, 32, register width in bits
- `NREGS`, 32, register count; power of 2, >= 2; register 0 hardwired to zero
- `NRD`, 2, read ports per read transaction; >= 1
- `AW`, derived localparam `$clog2(NREGS)`; not overridable
- `clk_i`  in  1  clock
- `rst_n_i`  in  1  reset, synchronous, active-low
- `stb_read_i`, `cyc_read_i`  in  1  read request strobe/cycle
- `op_rs_i`  in  NRD*AW  source indices; port k is at `[k*AW +: AW]`
- `ack_read_o`  out  1  read complete
- `reg_rs_o`  out  NRD*XLEN  read data; port k is at `[k*XLEN +: XLEN]`
- `stb_write_i`, `cyc_write_i`  in  1  write request strobe/cycle
- `op_rd_i`  in  AW  destination index
- `reg_rd_i`  in  XLEN  write data
- `ack_write_o`  out  1  write complete
- `rsv_i`  in  1  single-cycle pulse; reserve (mark busy) `rsv_rd_i`
- `rsv_rd_i`  in  AW  register to reserve
- `flush_i`  in  1  clear all busy bits (pipeline flush)
- `busy_o`  out  NREGS  scoreboard state; bit 0 is always 0

## Operation
- Handshake per channel (read, write), identical rules:
  - Registered `sync_ack`.
  - `ack_o = sync_ack & stb_i`, so ack drops combinationally when stb drops.
  - While `sync_ack` = 1 it reloads from `stb_i`.
  - A new transaction is accepted when `stb & cyc & ~sync_ack`.
- Write accept:
  - Writes `reg_rd_i` to `op_rd_i` unless `op_rd_i` = 0.
  - Clears `busy[op_rd_i]`.
  - Sets write `sync_ack`.
  - Write to x0 is still acked.
- Read accept requires every port k to satisfy one of:
  - `busy[rs_k]` = 0, or
  - an accepted write to the same nonzero `op_rd_i` occurs in this cycle (bypass).
- Otherwise the read stalls: no ack, `reg_rs_o` unchanged, re-evaluated every cycle.
- Read data per port:
  - `rs_k` = 0 returns 0.
  - Else, if a same-cycle accepted write targets `rs_k`, returns `reg_rd_i` (bypass).
  - Else returns the array value.
- Read and write accepted in the same cycle: both acked on the next edge. There is no write priority.
- Scoreboard update order within one cycle (later wins):
  1. Write clears busy.
  2. Reserve sets busy.
  3. `flush_i` clears all bits.
- Read-accept evaluation uses the pre-update busy vector. A reserve in the same cycle as a read of that register does not stall that read.
- Reserve of x0 is ignored.
- Reserve of an already-busy register: busy stays 1. There is no counting; one write clears it.

## Timing
- Read latency: 1 cycle from acceptance to `ack_read_o`/`reg_rs_o`. Stall cycles add to this.
- Write latency: 1 cycle. The written value is visible to the array on the next edge and to the bypass in the same cycle.
- `busy_o` is registered. A reserve in cycle N shows in `busy_o` in cycle N+1.
- Back-to-back transactions: stb must drop for at least one cycle between transactions (ack reload rule). Maximum rate is 1 transaction per 2 cycles per channel.
- Reset (`rst_n_i` = 0 at edge):
  - `sync_ack` (read and write) = 0, `reg_rs_o` = 0, busy = 0.
  - Array contents are not reset, except that x0 reads 0 by construction.
- Reset mid-transaction: a pending stalled read is dropped. The requester must re-present stb after reset.
- Flush while a read is stalled on a busy source: the read is accepted the cycle after flush, returning the array value.

## Structure
- `regfile_pkg`: default `XLEN`/`NREGS`/`NRD` constants and the `reg_idx_t` typedef (`logic [AW-1:0]`) shared with decode and writeback.
- Sub-module `regfile_scoreboard`:
  - Busy vector with clear/set/flush ports.
  - Combinational `stall_o` for the `NRD` source indices, including the bypass exemption.
- Top module: array (`syn_ramstyle="block_ram"`), bypass muxes, two handshake FSMs.

## Test plan
- Reset, then write x5 = 0xDEADBEEF, then read rs = {x5, x0} -> ack after 1 cycle; `reg_rs_o` = {0xDEADBEEF, 0}.
- Read {x3, x4} and write x3 = 0x12345678 in the same cycle -> both acked on the next edge; port0 = 0x12345678 (bypass).
- Reserve x7; two cycles later read {x7, x1} -> no ack; then write x7 = 0xA5A5A5A5 -> read acks in the write's cycle+1 with port0 = 0xA5A5A5A5; `busy_o[7]` = 0.
- Reserve x9, then flush with a read of x9 stalled -> `busy_o` = 0 next cycle; read acks one cycle later with the old x9 value.
- Write x0 = 0xFFFFFFFF and reserve x0 -> write acked; x0 reads 0; `busy_o[0]` = 0.
- Apply `rst_n_i` = 0 during a stalled read with x7 busy -> `ack_read_o` = 0, `busy_o` = 0, `reg_rs_o` = 0; after release, new reads complete normally.
